// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin write-back arbiter for the 16x16 register file's
//            single write port, plus a 16-cycle clear sequencer that zeroes
//            every register through that same port.
// Options  : define REG0_ZERO_EN to make register 0 read-only zero (granted
//            writes to address 0 complete but do not assert wr_en).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [4*N_REQ-1:0]    req_add,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  wr_en,
    output logic [3:0]            wr_reg_add,
    output logic [15:0]           wr_data
);

    localparam logic [3:0] c_LAST_REG = 4'd15;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_ptr;
    logic [1:0]  w_ptr_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        w_found;
    logic [1:0]  w_sel;
    logic [1:0]  w_idx;
    logic [3:0]  w_sel_add;
    logic [15:0] w_sel_data;

    logic        w_wr_en_nxt;
    logic [3:0]  w_add_nxt;
    logic [15:0] w_data_nxt;
    logic        w_done_nxt;

    // (base + off) mod N_REQ; both operands are already below N_REQ
    function automatic logic [1:0] f_wrap_inc(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 3'(N_REQ)) begin
            sum = sum - 3'(N_REQ);
        end
        return sum[1:0];
    endfunction

    // Round-robin search starting at the pointer; suppressed in CLEAR and when a clear is requested
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        if (r_state == ST_ARB && !clr_start) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_idx = f_wrap_inc(r_ptr, 2'(k));
                for (int i = 0; i < N_REQ; i++) begin
                    if (!w_found && w_idx == 2'(i) && req[i]) begin
                        w_found = 1'b1;
                        w_sel   = 2'(i);
                    end
                end
            end
        end
    end

    // One-hot grant and the address/data mux for the winning requester
    always_comb begin
        gnt        = '0;
        w_sel_add  = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_found && w_sel == 2'(i)) begin
                gnt[i]     = 1'b1;
                w_sel_add  = req_add[4*i +: 4];
                w_sel_data = req_data[16*i +: 16];
            end
        end
    end

    // Next-state, pointer, counter and write-port values
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_wr_en_nxt = 1'b0;
        w_add_nxt   = wr_reg_add;
        w_data_nxt  = wr_data;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (clr_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else if (w_found) begin
                    w_ptr_nxt  = f_wrap_inc(w_sel, 2'd1);
                    w_add_nxt  = w_sel_add;
                    w_data_nxt = w_sel_data;
`ifdef REG0_ZERO_EN
                    // Register 0 is hardwired zero: the transfer completes but is not written
                    w_wr_en_nxt = (w_sel_add != 4'd0);
`else
                    w_wr_en_nxt = 1'b1;
`endif
                end
            end
            ST_CLEAR: begin
                // clr_start is ignored here so the sequence never restarts
                w_wr_en_nxt = 1'b1;
                w_add_nxt   = r_cnt;
                w_data_nxt  = '0;
                w_cnt_nxt   = r_cnt + 4'd1;
                if (r_cnt == c_LAST_REG) begin
                    w_state_nxt = ST_ARB;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // State, pointer and clear counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered write port toward the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_reg_add <= '0;
            wr_data    <= '0;
            clr_done   <= 1'b0;
        end else begin
            wr_en      <= w_wr_en_nxt;
            wr_reg_add <= w_add_nxt;
            wr_data    <= w_data_nxt;
            clr_done   <= w_done_nxt;
        end
    end

    assign clr_busy = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed, table-driven bench for regfile_wb_arbiter (N_REQ=3)
//            with hand-written sequences for the clear/reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NR = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req;
    logic [4*NR-1:0]  req_add;
    logic [16*NR-1:0] req_data;
    logic [NR-1:0]  gnt;
    logic           clr_start;
    logic           clr_busy;
    logic           clr_done;
    logic           wr_en;
    logic [3:0]     wr_reg_add;
    logic [15:0]    wr_data;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.N_REQ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_add    (req_add),
        .req_data   (req_data),
        .gnt        (gnt),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .wr_en      (wr_en),
        .wr_reg_add (wr_reg_add),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [11:0] add;
        logic [47:0] data;
        logic [2:0]  gnt;
        logic        wr_en;
        logic [3:0]  wadd;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a0, a1, a2;
        logic [47:0] d0, d1, d2;
        int writes, dones;
        logic [3:0] done_add;

        a0 = {4'd5, 4'd4, 4'd3};
        d0 = {16'h3333, 16'h2222, 16'h1111};
        a1 = {4'd9, 4'd4, 4'd3};
        d1 = {16'hBEEF, 16'h2222, 16'h1111};
        a2 = {4'd9, 4'd4, 4'd0};
        d2 = {16'hBEEF, 16'h2222, 16'hFFFF};

        // Rotating grants, single-requester hold, mixed patterns, idle hold
        vecs[0]  = '{3'b111, a0, d0, 3'b001, 1'b1, 4'd3, 16'h1111};
        vecs[1]  = '{3'b111, a0, d0, 3'b010, 1'b1, 4'd4, 16'h2222};
        vecs[2]  = '{3'b111, a0, d0, 3'b100, 1'b1, 4'd5, 16'h3333};
        vecs[3]  = '{3'b111, a0, d0, 3'b001, 1'b1, 4'd3, 16'h1111};
        vecs[4]  = '{3'b000, a1, d1, 3'b000, 1'b0, 4'd3, 16'h1111};
        vecs[5]  = '{3'b100, a1, d1, 3'b100, 1'b1, 4'd9, 16'hBEEF};
        vecs[6]  = '{3'b100, a1, d1, 3'b100, 1'b1, 4'd9, 16'hBEEF};
        vecs[7]  = '{3'b100, a1, d1, 3'b100, 1'b1, 4'd9, 16'hBEEF};
        vecs[8]  = '{3'b011, a1, d1, 3'b001, 1'b1, 4'd3, 16'h1111};
        vecs[9]  = '{3'b101, a1, d1, 3'b100, 1'b1, 4'd9, 16'hBEEF};
        vecs[10] = '{3'b010, a1, d1, 3'b010, 1'b1, 4'd4, 16'h2222};
        vecs[11] = '{3'b011, a1, d1, 3'b001, 1'b1, 4'd3, 16'h1111};
        vecs[12] = '{3'b000, a1, d1, 3'b000, 1'b0, 4'd3, 16'h1111};

        rst = 1'b1; req = '0; req_add = a0; req_data = d0; clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_add", 64'(wr_reg_add), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_busy", 64'(clr_busy), 64'd0);
        chk("reset_done", 64'(clr_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            req = vecs[v].req; req_add = vecs[v].add; req_data = vecs[v].data;
            #1;
            chk($sformatf("vec%0d_gnt", v), 64'(gnt), 64'(vecs[v].gnt));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wr_en", v), 64'(wr_en), 64'(vecs[v].wr_en));
            chk($sformatf("vec%0d_wr_add", v), 64'(wr_reg_add), 64'(vecs[v].wadd));
            chk($sformatf("vec%0d_wr_data", v), 64'(wr_data), 64'(vecs[v].wdata));
            chk($sformatf("vec%0d_busy", v), 64'(clr_busy), 64'd0);
            chk($sformatf("vec%0d_done", v), 64'(clr_done), 64'd0);
        end

        // Clear with req[1] pending (pointer is 1 here)
        @(negedge clk);
        req = 3'b010; req_add = a1; req_data = d1; clr_start = 1'b1;
        #1;
        chk("clrA_start_gnt", 64'(gnt), 64'd0);
        @(posedge clk);
        #1;
        chk("clrA_start_wr_en", 64'(wr_en), 64'd0);
        chk("clrA_start_busy", 64'(clr_busy), 64'd1);
        @(negedge clk);
        clr_start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            #1;
            chk($sformatf("clrA%0d_gnt", j), 64'(gnt), 64'd0);
            chk($sformatf("clrA%0d_busy", j), 64'(clr_busy), 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("clrA%0d_wr_en", j), 64'(wr_en), 64'd1);
            chk($sformatf("clrA%0d_wr_add", j), 64'(wr_reg_add), 64'(j));
            chk($sformatf("clrA%0d_wr_data", j), 64'(wr_data), 64'd0);
            chk($sformatf("clrA%0d_done", j), 64'(clr_done), 64'(j == 15));
            @(negedge clk);
        end
        #1;
        chk("clrA_after_gnt", 64'(gnt), 64'b010);
        chk("clrA_after_busy", 64'(clr_busy), 64'd0);
        @(posedge clk);
        #1;
        chk("clrA_after_wr_en", 64'(wr_en), 64'd1);
        chk("clrA_after_wr_add", 64'(wr_reg_add), 64'd4);
        chk("clrA_after_wr_data", 64'(wr_data), 64'h2222);
        chk("clrA_after_done", 64'(clr_done), 64'd0);

        // Clear with a second clr_start pulse in the middle of the sequence
        @(negedge clk);
        req = '0; clr_start = 1'b1;
        @(posedge clk);
        writes = 0; dones = 0; done_add = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            clr_start = (c == 4);
            @(posedge clk);
            #1;
            if (wr_en) writes++;
            if (clr_done) begin
                dones++;
                done_add = wr_reg_add;
            end
        end
        clr_start = 1'b0;
        chk("clrB_writes", 64'(writes), 64'd16);
        chk("clrB_dones", 64'(dones), 64'd1);
        chk("clrB_done_add", 64'(done_add), 64'd15);
        chk("clrB_busy_end", 64'(clr_busy), 64'd0);

        // Reset during the 5th CLEAR cycle
        @(negedge clk);
        clr_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("clrC_pre_wr_add", 64'(wr_reg_add), 64'd3);
        chk("clrC_pre_busy", 64'(clr_busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("clrC_rst_wr_en", 64'(wr_en), 64'd0);
        chk("clrC_rst_busy", 64'(clr_busy), 64'd0);
        chk("clrC_rst_done", 64'(clr_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("clrC_post_wr_en", 64'(wr_en), 64'd0);
        chk("clrC_post_done", 64'(clr_done), 64'd0);
        chk("clrC_post_busy", 64'(clr_busy), 64'd0);
        @(negedge clk);
        req = 3'b001; req_add = a1; req_data = d1;
        #1;
        chk("clrC_arb_gnt", 64'(gnt), 64'b001);
        @(posedge clk);
        #1;
        chk("clrC_arb_wr_en", 64'(wr_en), 64'd1);
        chk("clrC_arb_wr_add", 64'(wr_reg_add), 64'd3);

        // Write to register 0
        @(negedge clk);
        req = 3'b001; req_add = a2; req_data = d2;
        #1;
        chk("reg0_gnt", 64'(gnt), 64'b001);
        @(posedge clk);
        #1;
`ifdef REG0_ZERO_EN
        chk("reg0_wr_en", 64'(wr_en), 64'd0);
`else
        chk("reg0_wr_en", 64'(wr_en), 64'd1);
        chk("reg0_wr_add", 64'(wr_reg_add), 64'd0);
        chk("reg0_wr_data", 64'(wr_data), 64'hFFFF);
`endif
        @(negedge clk);
        req = '0;
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
